// File: rtl/regfile_param.sv
// ---------------------------------------------------------------------------
// regfile_param
//   Parametrised CPU register file.
//   - Two combinational read ports.
//   - One write port with per-byte write enables.
//   - Optional write-through bypass and optional hardwired zero register.
//   - Sequenced bulk-clear engine that zeroes one register per cycle.
//
// Parameters
//   WIDTH       data width in bits (multiple of 8)
//   ADDR_WIDTH  address width, DEPTH = 2**ADDR_WIDTH
//   BYPASS      1 = same-cycle write data is visible on the read ports
//   ZERO_REG    1 = register 0 reads 0 and ignores writes
//
// Ports
//   Clk, Reset                    clock, async active-high reset
//   ReadRegister1/2, ReadData1/2  read ports (combinational)
//   WriteRegister, WriteData      write address / data
//   WriteByteEn, RegWrite         per-byte enables, write strobe
//   ClearReq                      bulk-clear request (level, sampled at posedge)
//   ClearBusy                     high while the clear engine runs
//   ClearDone                     one-cycle pulse when a clear completes
// ---------------------------------------------------------------------------
module regfile_param #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] ReadRegister1,
    input  logic [ADDR_WIDTH-1:0] ReadRegister2,
    output logic [WIDTH-1:0]      ReadData1,
    output logic [WIDTH-1:0]      ReadData2,
    input  logic [ADDR_WIDTH-1:0] WriteRegister,
    input  logic [WIDTH-1:0]      WriteData,
    input  logic [WIDTH/8-1:0]    WriteByteEn,
    input  logic                  RegWrite,
    input  logic                  ClearReq,
    output logic                  ClearBusy,
    output logic                  ClearDone
);

    localparam int DEPTH  = 1 << ADDR_WIDTH;
    localparam int NBYTES = WIDTH / 8;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    logic [WIDTH-1:0]      regs_q [DEPTH];
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    logic [WIDTH-1:0]      byteMask;
    logic [WIDTH-1:0]      wrMerged;
    logic                  writeEn;
    logic                  bypassOk;

    // Expand the per-byte enables into a bit mask over the data word.
    always_comb begin
        byteMask = '0;
        for (int i = 0; i < NBYTES; i++) begin
            byteMask[8*i +: 8] = {8{WriteByteEn[i]}};
        end
    end

    // The value the target register will hold after the write: new bytes
    // where enabled, stored bytes elsewhere. Shared by the write path and
    // the bypass path so both always agree.
    assign wrMerged = (WriteData & byteMask) | (regs_q[WriteRegister] & ~byteMask);

    // Writes and forwarding are only live while the clear engine is idle.
    assign writeEn  = (state_q == IDLE) && RegWrite &&
                      !((ZERO_REG != 0) && (WriteRegister == '0));
    assign bypassOk = (BYPASS != 0) && (state_q == IDLE) && RegWrite;

    // Read port 1: zero register has priority over bypass, bypass over storage.
    always_comb begin
        ReadData1 = regs_q[ReadRegister1];
        if ((ZERO_REG != 0) && (ReadRegister1 == '0)) begin
            ReadData1 = '0;
        end else if (bypassOk && (ReadRegister1 == WriteRegister)) begin
            ReadData1 = wrMerged;
        end
    end

    // Read port 2: identical priority, independent address.
    always_comb begin
        ReadData2 = regs_q[ReadRegister2];
        if ((ZERO_REG != 0) && (ReadRegister2 == '0)) begin
            ReadData2 = '0;
        end else if (bypassOk && (ReadRegister2 == WriteRegister)) begin
            ReadData2 = wrMerged;
        end
    end

    // Clear engine next-state. The pointer walks 0..DEPTH-1; the edge that
    // clears the all-ones address returns to IDLE and raises ClearDone for
    // exactly one cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (ClearReq) begin
                    state_d = CLEAR;
                    ptr_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (&ptr_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Storage and FSM state. Reset clears everything at once; in CLEAR the
    // engine owns the write port and normal writes are dropped.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (state_q == CLEAR) begin
                regs_q[ptr_q] <= '0;
            end else if (writeEn) begin
                regs_q[WriteRegister] <= wrMerged;
            end
        end
    end

    assign ClearBusy = busy_q;
    assign ClearDone = done_q;

endmodule

// File: tb/tb_regfile_param.sv
// ---------------------------------------------------------------------------
// tb_regfile_param
//   Drives two register files from the same stimulus:
//     dutA: BYPASS=1, ZERO_REG=1 (defaults)
//     dutB: BYPASS=0, ZERO_REG=0
//   Read expectations are pushed to a scoreboard queue when stimulus is
//   driven and popped when the outputs are sampled.
// ---------------------------------------------------------------------------
module tb_regfile_param;

    logic        Clk;
    logic        Reset;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
    logic [31:0] WriteData;
    logic [3:0]  WriteByteEn;
    logic        RegWrite, ClearReq;

    logic [31:0] rdA1, rdA2, rdB1, rdB2;
    logic        busyA, doneA, busyB, doneB;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [31:0] a1, a2, b1, b2;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        string       name;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [3:0]  en;
        logic        we;
        logic [31:0] expA;
        logic [31:0] expB;
    } vec_t;
    vec_t vecs[9];

    regfile_param dutA (
        .Clk(Clk), .Reset(Reset),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rdA1), .ReadData2(rdA2),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .WriteByteEn(WriteByteEn), .RegWrite(RegWrite),
        .ClearReq(ClearReq), .ClearBusy(busyA), .ClearDone(doneA)
    );

    regfile_param #(.BYPASS(0), .ZERO_REG(0)) dutB (
        .Clk(Clk), .Reset(Reset),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .ReadData1(rdB1), .ReadData2(rdB2),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .WriteByteEn(WriteByteEn), .RegWrite(RegWrite),
        .ClearReq(ClearReq), .ClearBusy(busyB), .ClearDone(doneB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic expectReads(input string name, input logic [31:0] a1, input logic [31:0] a2,
                               input logic [31:0] b1, input logic [31:0] b2);
        exp_t e;
        e.name = name; e.a1 = a1; e.a2 = a2; e.b1 = b1; e.b2 = b2;
        sbq.push_back(e);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard: got empty queue want entry");
        end else begin
            e = sbq.pop_front();
            checkVal({e.name, " A1"}, rdA1, e.a1);
            checkVal({e.name, " A2"}, rdA2, e.a2);
            checkVal({e.name, " B1"}, rdB1, e.b1);
            checkVal({e.name, " B2"}, rdB2, e.b2);
        end
    endtask

    // Drive all write/read inputs right after a falling edge.
    task automatic applyStimulus(input logic [4:0] wr, input logic [31:0] wd, input logic [3:0] en,
                                 input logic we, input logic [4:0] r1, input logic [4:0] r2);
        @(negedge Clk);
        WriteRegister = wr;
        WriteData     = wd;
        WriteByteEn   = en;
        RegWrite      = we;
        ReadRegister1 = r1;
        ReadRegister2 = r2;
    endtask

    task automatic checkAllZero(input string tag);
        for (int a = 0; a < 32; a++) begin
            ReadRegister1 = 5'(a);
            ReadRegister2 = 5'(31 - a);
            #1;
            expectReads(tag, 32'd0, 32'd0, 32'd0, 32'd0);
            checkOutput();
        end
    endtask

    task automatic checkCtrl(input string tag, input logic busyExp, input logic doneExp);
        checkVal({tag, " busyA"}, {31'd0, busyA}, {31'd0, busyExp});
        checkVal({tag, " doneA"}, {31'd0, doneA}, {31'd0, doneExp});
        checkVal({tag, " busyB"}, {31'd0, busyB}, {31'd0, busyExp});
        checkVal({tag, " doneB"}, {31'd0, doneB}, {31'd0, doneExp});
    endtask

    initial begin
        int  busyCntA, busyCntB, doneEarly, donePulses;
        bit  finished;

        vecs[0] = '{"wr 42",      5'd2,  32'd42,        4'hF, 1'b1, 32'd42,        32'd42};
        vecs[1] = '{"wr 15",      5'd2,  32'd15,        4'hF, 1'b1, 32'd15,        32'd15};
        vecs[2] = '{"no regwrite",5'd2,  32'd20,        4'hF, 1'b0, 32'd15,        32'd15};
        vecs[3] = '{"full word",  5'd5,  32'hAABBCCDD,  4'hF, 1'b1, 32'hAABBCCDD,  32'hAABBCCDD};
        vecs[4] = '{"byte en",    5'd5,  32'h11223344,  4'h5, 1'b1, 32'hAA22CC44,  32'hAA22CC44};
        vecs[5] = '{"zero reg",   5'd0,  32'd15,        4'hF, 1'b1, 32'd0,         32'd15};
        vecs[6] = '{"no bytes",   5'd5,  32'hFFFFFFFF,  4'h0, 1'b1, 32'hAA22CC44,  32'hAA22CC44};
        vecs[7] = '{"top byte",   5'd31, 32'hDEADBEEF,  4'h8, 1'b1, 32'hDE000000,  32'hDE000000};
        vecs[8] = '{"reg7",       5'd7,  32'd9,         4'hF, 1'b1, 32'd9,         32'd9};

        Reset = 1'b1;
        ClearReq = 1'b0;
        RegWrite = 1'b0;
        WriteRegister = '0;
        WriteData = '0;
        WriteByteEn = '0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        #2;
        checkCtrl("reset", 1'b0, 1'b0);
        checkAllZero("reset read");

        // Table-driven writes: write on one edge, read back after it.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].data, vecs[i].en, vecs[i].we, vecs[i].addr, vecs[i].addr);
            expectReads(vecs[i].name, vecs[i].expA, vecs[i].expA, vecs[i].expB, vecs[i].expB);
            applyStimulus(5'd0, 32'd0, 4'h0, 1'b0, vecs[i].addr, vecs[i].addr);
            #2;
            checkOutput();
        end

        // Bypass with byte merge into reg 5.
        applyStimulus(5'd5, 32'h00000077, 4'h1, 1'b1, 5'd5, 5'd0);
        expectReads("bypass merge pre", 32'hAA22CC77, 32'd0, 32'hAA22CC44, 32'd15);
        #2; checkOutput();
        applyStimulus(5'd0, 32'd0, 4'h0, 1'b0, 5'd5, 5'd0);
        expectReads("bypass merge post", 32'hAA22CC77, 32'd0, 32'hAA22CC77, 32'd15);
        #2; checkOutput();

        // Bypass of a full word into reg 7.
        applyStimulus(5'd7, 32'd100, 4'hF, 1'b1, 5'd7, 5'd7);
        expectReads("bypass reg7 pre", 32'd100, 32'd100, 32'd9, 32'd9);
        #2; checkOutput();
        applyStimulus(5'd0, 32'd0, 4'h0, 1'b0, 5'd7, 5'd7);
        expectReads("bypass reg7 post", 32'd100, 32'd100, 32'd100, 32'd100);
        #2; checkOutput();

        // Zero register must win over bypass.
        applyStimulus(5'd0, 32'h1234, 4'hF, 1'b1, 5'd0, 5'd0);
        expectReads("bypass reg0 pre", 32'd0, 32'd0, 32'd15, 32'd15);
        #2; checkOutput();
        applyStimulus(5'd0, 32'd0, 4'h0, 1'b0, 5'd0, 5'd0);
        expectReads("bypass reg0 post", 32'd0, 32'd0, 32'h1234, 32'h1234);
        #2; checkOutput();

        // Bulk clear: fill 1..31 with their index, then pulse ClearReq.
        for (int a = 1; a < 32; a++) applyStimulus(5'(a), 32'(a), 4'hF, 1'b1, 5'd0, 5'd0);
        applyStimulus(5'd0, 32'd0, 4'h0, 1'b0, 5'd9, 5'd10);
        ClearReq = 1'b1;
        busyCntA = 0; busyCntB = 0; doneEarly = 0; finished = 0;
        for (int cyc = 0; cyc < 100 && !finished; cyc++) begin
            @(negedge Clk);
            ClearReq = 1'b0;
            if (cyc == 20) begin
                WriteRegister = 5'd3; WriteData = 32'h55; WriteByteEn = 4'hF;
                RegWrite = 1'b1; ReadRegister1 = 5'd3;
            end
            if (cyc == 25) RegWrite = 1'b0;
            #2;
            if (cyc == 10) begin
                expectReads("clear partial", 32'd0, 32'd10, 32'd0, 32'd10);
                checkOutput();
            end
            if (cyc == 22) begin
                expectReads("clear no write/bypass", 32'd0, 32'd0, 32'd0, 32'd0);
                checkOutput();
            end
            if (busyB) busyCntB++;
            if (busyA && (doneA || doneB)) doneEarly++;
            if (busyA) busyCntA++;
            else begin
                finished = 1;
                checkCtrl("clear done", 1'b0, 1'b1);
            end
        end
        checkVal("clear finished", {31'd0, finished}, 32'd1);
        checkVal("busy cycles A", 32'(busyCntA), 32'd32);
        checkVal("busy cycles B", 32'(busyCntB), 32'd32);
        checkVal("done during busy", 32'(doneEarly), 32'd0);
        @(negedge Clk);
        #2;
        checkCtrl("after done", 1'b0, 1'b0);
        checkAllZero("after clear");

        // Reset in the middle of a clear.
        for (int a = 1; a < 32; a++) applyStimulus(5'(a), 32'(a), 4'hF, 1'b1, 5'd0, 5'd0);
        applyStimulus(5'd0, 32'd0, 4'h0, 1'b0, 5'd0, 5'd0);
        ClearReq = 1'b1;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            @(negedge Clk);
            ClearReq = 1'b0;
        end
        #2;
        checkCtrl("pre reset busy", 1'b1, 1'b0);
        Reset = 1'b1;
        #1;
        checkCtrl("mid-clear reset", 1'b0, 1'b0);
        checkAllZero("mid-clear reset");
        @(negedge Clk);
        Reset = 1'b0;
        donePulses = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge Clk);
            #2;
            if (doneA || doneB || busyA || busyB) donePulses++;
        end
        checkVal("no done after reset", 32'(donePulses), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
